// File: rtl/color_frame_loader.sv
// color_frame_loader
// Assembles narrow HPS colour beats into wide colour-memory words and streams
// one frame of FRAME_WORDS words to consecutive addresses. The first beat of
// a frame is flagged with in_sof. Framing errors raise a sticky err_sync.
// Each completed frame yields a one-cycle new_frame pulse and bumps
// frame_count.
module color_frame_loader #(
  parameter int W_DATA_WIDTH  = 128,
  parameter int IN_DATA_WIDTH = 32,
  parameter int NB_LED_ROWS   = 32,
  parameter int NB_ANGLES     = 128,
  parameter int BIT_PER_COLOR = 8,
  localparam int BEATS        = W_DATA_WIDTH / IN_DATA_WIDTH,
  localparam int FRAME_WORDS  = 3 * BIT_PER_COLOR * NB_LED_ROWS * NB_ANGLES / W_DATA_WIDTH,
  localparam int ADDR_W       = $clog2(2 * FRAME_WORDS) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_DATA_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        color_w_addr,
  output logic [W_DATA_WIDTH-1:0]  color_w_data,
  output logic                     color_w_enable,
  output logic                     new_frame,
  output logic                     err_sync,
  input  logic                     err_clear,
  output logic [15:0]              frame_count
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [BEAT_W-1:0]         beat_cnt_q;
  logic [ADDR_W-1:0]         word_cnt_q;
  logic [W_DATA_WIDTH-1:0]   buf_q;
  logic                      in_ready_q;
  logic [ADDR_W-1:0]         color_w_addr_q;
  logic [W_DATA_WIDTH-1:0]   color_w_data_q;
  logic                      color_w_enable_q;
  logic                      new_frame_q;
  logic                      err_sync_q;
  logic [15:0]               frame_count_q;

  logic                      xfer;
  logic                      err_set;
  logic [BEAT_W-1:0]         beat_idx;
  logic [ADDR_W-1:0]         word_idx;
  logic                      last_beat;
  logic                      last_word;
  logic [W_DATA_WIDTH-1:0]   word_d;

  // A beat moves only when the source offers it and we are ready for it.
  assign xfer = in_valid & in_ready_q;

  // Framing errors: a beat without sof while idle, or an sof in mid-frame.
  assign err_set = xfer & (((state_q == IDLE) & ~in_sof) |
                           ((state_q == LOAD) &  in_sof));

  // Position of the incoming beat; an sof beat always restarts at word 0,
  // beat 0. word_d is the buffered word with this beat dropped into its lane.
  always_comb begin
    beat_idx  = in_sof ? '0 : beat_cnt_q;
    word_idx  = in_sof ? '0 : word_cnt_q;
    last_beat = (beat_idx == BEAT_W'(BEATS - 1));
    last_word = (word_idx == ADDR_W'(FRAME_WORDS - 1));
    word_d    = buf_q;
    word_d[beat_idx*IN_DATA_WIDTH +: IN_DATA_WIDTH] = in_data;
  end

  // Beat assembly buffer, little-endian lanes.
  // NOTE: pure datapath with no reset; every lane is rewritten before the
  // word it belongs to is ever written out, so its power-up value is unused.
  always_ff @(posedge clk) begin
    if (xfer) begin
      buf_q <= word_d;
    end
  end

  // Control FSM with registered outputs: word/beat sequencing, memory write
  // strobe, end-of-frame pulse, frame counter and sticky error flag.
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      beat_cnt_q       <= '0;
      word_cnt_q       <= '0;
      in_ready_q       <= 1'b0;
      color_w_addr_q   <= '0;
      color_w_data_q   <= '0;
      color_w_enable_q <= 1'b0;
      new_frame_q      <= 1'b0;
      err_sync_q       <= 1'b0;
      frame_count_q    <= '0;
    end else begin
      color_w_enable_q <= 1'b0;
      new_frame_q      <= 1'b0;
      // A set in the same cycle as err_clear wins.
      err_sync_q       <= err_set | (err_sync_q & ~err_clear);

      case (state_q)
        IDLE, LOAD: begin
          in_ready_q <= 1'b1;
          // In IDLE only an sof beat starts a frame; others are dropped.
          if (xfer && (in_sof || (state_q == LOAD))) begin
            state_q <= LOAD;
            if (last_beat) begin
              color_w_enable_q <= 1'b1;
              color_w_addr_q   <= word_idx;
              color_w_data_q   <= word_d;
              beat_cnt_q       <= '0;
              if (last_word) begin
                // Stop accepting until the frame has been announced.
                state_q    <= DONE;
                in_ready_q <= 1'b0;
                word_cnt_q <= '0;
              end else begin
                word_cnt_q <= word_idx + 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_idx + 1'b1;
              word_cnt_q <= word_idx;
            end
          end
        end

        DONE: begin
          // The final write is on the bus this cycle; announce the frame
          // next cycle and keep the input stalled through the pulse.
          in_ready_q    <= 1'b0;
          new_frame_q   <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
          state_q       <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign color_w_addr   = color_w_addr_q;
  assign color_w_data   = color_w_data_q;
  assign color_w_enable = color_w_enable_q;
  assign new_frame      = new_frame_q;
  assign err_sync       = err_sync_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_color_frame_loader.sv
// Self-checking bench for color_frame_loader. The reference model keeps the
// beats of the current frame in a queue and turns every group of four into
// an expected (address, word) pair. A negedge monitor compares every memory
// write and the new_frame timing against that model.
module tb_color_frame_loader;

  localparam int W           = 128;
  localparam int IN          = 32;
  localparam int BEATS       = 4;
  localparam int FRAME_WORDS = 768;
  localparam int FRAME_BEATS = FRAME_WORDS * BEATS;
  localparam int ADDR_W      = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN-1:0]     in_data;
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic [ADDR_W-1:0] color_w_addr;
  logic [W-1:0]      color_w_data;
  logic              color_w_enable;
  logic              new_frame;
  logic              err_sync;
  logic              err_clear;
  logic [15:0]       frame_count;

  color_frame_loader dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_ready       (in_ready),
    .color_w_addr   (color_w_addr),
    .color_w_data   (color_w_data),
    .color_w_enable (color_w_enable),
    .new_frame      (new_frame),
    .err_sync       (err_sync),
    .err_clear      (err_clear),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      data;
  } wr_t;

  wr_t           exp_q[$];
  logic [IN-1:0] m_part[$];
  bit            m_loading;
  int            m_word;
  logic [15:0]   m_frames;
  bit            m_err;

  function automatic void model_reset();
    m_loading = 1'b0;
    m_part.delete();
    m_word    = 0;
    m_frames  = '0;
    m_err     = 1'b0;
  endfunction

  function automatic void model_beat(input logic [IN-1:0] d, input bit sof);
    logic [W-1:0] word;
    if (sof) begin
      if (m_loading) m_err = 1'b1;
      m_loading = 1'b1;
      m_part.delete();
      m_word = 0;
    end else if (!m_loading) begin
      m_err = 1'b1;
      return;
    end
    m_part.push_back(d);
    if (m_part.size() == BEATS) begin
      word = '0;
      for (int k = 0; k < BEATS; k++) word = word | (W'(m_part[k]) << (IN * k));
      exp_q.push_back('{addr: ADDR_W'(m_word), data: word});
      m_part.delete();
      m_word++;
      if (m_word == FRAME_WORDS) begin
        m_loading = 1'b0;
        m_word    = 0;
        m_frames++;
      end
    end
  endfunction

  // ---------------- monitor ----------------
  int wr_count = 0;
  int nf_count = 0;
  bit prev_final = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_final = 1'b0;
    end else begin
      if (prev_final) check("new_frame_after_last_write", W'(new_frame), W'(1));
      if (new_frame) begin
        nf_count++;
        check("new_frame_follows_last_write", W'(prev_final), W'(1));
        check("in_ready_low_at_new_frame", W'(in_ready), W'(0));
      end
      prev_final = 1'b0;
      if (color_w_enable) begin
        wr_count++;
        check("write_expected", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", W'(color_w_addr), W'(e.addr));
          check("wr_data", color_w_data, e.data);
        end
        prev_final = (color_w_addr == ADDR_W'(FRAME_WORDS - 1));
      end
    end
  end

  // ---------------- driver helpers ----------------
  logic [IN-1:0] frame_buf [FRAME_BEATS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IN-1:0] d, input bit sof, input int gap);
    bit rdy;
    int n;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    n = 0;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("in_ready_timeout", W'(rdy), W'(1));
    else model_beat(d, sof);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < FRAME_BEATS; i++) frame_buf[i] = $urandom();
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < FRAME_BEATS; i++)
      send_beat(frame_buf[i], i == 0, $urandom_range(0, max_gap));
  endtask

  task automatic wait_nf(input int target);
    int n = 0;
    while (nf_count < target && n < 20) begin
      tick();
      n++;
    end
    check("new_frame_count", W'(nf_count), W'(target));
    check("frame_count", W'(frame_count), W'(m_frames));
    check("new_frame_one_cycle", W'(new_frame), W'(0));
    check("in_ready_back_after_frame", W'(in_ready), W'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},        W'(color_w_enable), W'(0));
    check({tag, "_new_frame"}, W'(new_frame),      W'(0));
    check({tag, "_err_sync"},  W'(err_sync),       W'(0));
    check({tag, "_frame_cnt"}, W'(frame_count),    W'(0));
    check({tag, "_addr"},      W'(color_w_addr),   W'(0));
    check({tag, "_data"},      color_w_data,       W'(0));
    check({tag, "_in_ready"},  W'(in_ready),       W'(0));
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_err = 1'b0;
    check("err_cleared", W'(err_sync), W'(m_err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] k_word;
    int           wr_snap;
    int           nf_snap;

    k_word    = 128'h00000004_00000003_00000002_00000001;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    err_clear = 1'b0;
    model_reset();

    // Reset state, then ready on the first edge after release.
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("in_ready_after_reset", W'(in_ready), W'(1));

    // Frame 1: directed first word 1..4, then random, no gaps.
    fill_random();
    for (int i = 0; i < BEATS; i++) frame_buf[i] = IN'(i + 1);
    for (int i = 0; i < FRAME_BEATS; i++) begin
      send_beat(frame_buf[i], i == 0, 0);
      if (i == BEATS - 1) begin
        check("first_word_we",   W'(color_w_enable), W'(1));
        check("first_word_addr", W'(color_w_addr),   W'(0));
        check("first_word_data", color_w_data,       k_word);
      end
    end
    wait_nf(1);
    check("err_clean_frame", W'(err_sync), W'(m_err));

    // Frame 2: same beats, random 0..5 cycle gaps.
    send_frame(5);
    wait_nf(2);
    check("err_gapped_frame", W'(err_sync), W'(m_err));

    // sof restart after 10 words plus 2 beats.
    for (int i = 0; i < 10 * BEATS + 2; i++) send_beat($urandom(), i == 0, 0);
    fill_random();
    nf_snap = nf_count;
    for (int i = 0; i < FRAME_BEATS; i++) begin
      send_beat(frame_buf[i], i == 0, 0);
      if (i == 0) check("err_on_restart", W'(err_sync), W'(m_err));
      if (i == BEATS - 1) begin
        check("restart_we",   W'(color_w_enable), W'(1));
        check("restart_addr", W'(color_w_addr),   W'(0));
      end
    end
    check("no_nf_for_aborted", W'(nf_count), W'(nf_snap));
    wait_nf(3);
    pulse_err_clear();

    // Reset, then beats without sof: discarded, error flagged.
    rst = 1'b1;
    #1;
    check_reset_outputs("reset2");
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    wr_snap = wr_count;
    for (int i = 0; i < 6; i++) send_beat($urandom(), 1'b0, $urandom_range(0, 2));
    tick();
    check("no_write_without_sof", W'(wr_count), W'(wr_snap));
    check("err_without_sof", W'(err_sync), W'(m_err));
    pulse_err_clear();
    // err_clear coinciding with an error event: set wins.
    err_clear = 1'b1;
    send_beat($urandom(), 1'b0, 0);
    err_clear = 1'b0;
    check("err_set_wins", W'(err_sync), W'(m_err));
    pulse_err_clear();

    // Reset asserted mid-frame.
    fill_random();
    for (int i = 0; i < 1000; i++) send_beat(frame_buf[i], i == 0, 0);
    tick();
    wr_snap = wr_count;
    nf_snap = nf_count;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_frame");
    check("no_pending_writes", W'(exp_q.size()), W'(0));
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("in_ready_after_mid_reset", W'(in_ready), W'(1));
    repeat (20) tick();
    check("no_write_after_abort", W'(wr_count), W'(wr_snap));
    check("no_nf_after_abort", W'(nf_count), W'(nf_snap));
    fill_random();
    send_frame(1);
    wait_nf(nf_snap + 1);
    check("frame_count_after_reset", W'(frame_count), W'(1));

    tick();
    check("all_writes_seen", W'(exp_q.size()), W'(0));
    check("final_err", W'(err_sync), W'(m_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/color_frame_loader.md
COLOR_FRAME_LOADER -- requirements
Module: color_frame_loader

Interface
REQ-001 SHALL have parameter W_DATA_WIDTH, default 128, the width of one colour-memory write word.
REQ-002 SHALL have parameter IN_DATA_WIDTH, default 32, the width of one HPS input beat; W_DATA_WIDTH is an integer multiple of it.
REQ-003 SHALL have parameter NB_LED_ROWS, default 32, the number of LED rows per band.
REQ-004 SHALL have parameter NB_ANGLES, default 128, the number of angular positions per turn.
REQ-005 SHALL have parameter BIT_PER_COLOR, default 8, the bits per colour channel.
REQ-006 SHALL derive localparams BEATS = W_DATA_WIDTH/IN_DATA_WIDTH (4), FRAME_WORDS = 3*BIT_PER_COLOR*NB_LED_ROWS*NB_ANGLES/W_DATA_WIDTH (768) and ADDR_W = $clog2(2*FRAME_WORDS)-1 (10).
REQ-007 SHALL have port clk, input, 1, the system clock; the block uses this one clock only.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port in_data, input, IN_DATA_WIDTH, one colour-data beat from the HPS.
REQ-010 SHALL have port in_valid, input, 1, indicating in_data is valid.
REQ-011 SHALL have port in_sof, input, 1, marking the first beat of a frame; it is qualified by in_valid.
REQ-012 SHALL have port in_ready, output, 1; a beat transfers on a clock edge where in_valid and in_ready are both 1.
REQ-013 SHALL have port color_w_addr, output, ADDR_W, the word address into the colour memory.
REQ-014 SHALL have port color_w_data, output, W_DATA_WIDTH, the packed write word.
REQ-015 SHALL have port color_w_enable, output, 1, a one-cycle write strobe.
REQ-016 SHALL have port new_frame, output, 1, a one-cycle pulse indicating a complete frame is in memory.
REQ-017 SHALL have port err_sync, output, 1, a sticky framing-error flag.
REQ-018 SHALL have port err_clear, input, 1, which clears err_sync synchronously.
REQ-019 SHALL have port frame_count, output, 16, the number of completed frames; it wraps from 0xFFFF to 0.

Function
REQ-020 SHALL implement the states IDLE, LOAD and DONE.
REQ-021 IDLE SHALL go to LOAD on a beat transfer with in_sof=1; that beat is beat 0 of word 0.
REQ-022 IDLE SHALL accept and discard a beat with in_sof=0, and SHALL set err_sync when it does so.
REQ-023 SHALL pack the beats of a word little-endian: beat k goes to bits [IN_DATA_WIDTH*(k+1)-1 : IN_DATA_WIDTH*k].
REQ-024 On the edge that transfers beat BEATS-1 of word w, SHALL register color_w_data and set color_w_addr=w, so that color_w_enable=1 during exactly the next cycle.
REQ-025 SHALL hold color_w_addr and color_w_data stable until the next write.
REQ-026 SHALL increment the word index after each completed word.
REQ-027 SHALL go LOAD -> DONE when word FRAME_WORDS-1 completes.
REQ-028 In DONE, SHALL drive in_ready=0 and new_frame=1 for exactly one cycle; that cycle is the cycle after the final color_w_enable cycle.
REQ-029 In DONE, SHALL increment frame_count and then return to IDLE.
REQ-030 SHALL drive in_ready=1 in IDLE and in LOAD.
REQ-031 SHALL accept back-to-back beats at a rate of 1 per cycle with no bubbles inside a frame.
REQ-032 A beat with in_sof=1 received in LOAD SHALL discard any partial word, set err_sync, and restart at word 0 with this beat as beat 0.
REQ-033 After an in_sof restart, words already written SHALL be overwritten and no new_frame SHALL be issued for the aborted frame.
REQ-034 SHALL leave the packing state unchanged in any cycle where in_valid=0.
REQ-035 If err_clear and an error-setting event occur in the same cycle, err_sync SHALL be 1 (set wins).
REQ-036 SHALL never drive color_w_addr >= FRAME_WORDS; the word index wraps to 0 only via DONE.

Reset
REQ-037 While rst=1, SHALL drive color_w_enable=0, new_frame=0, err_sync=0, frame_count=0, color_w_addr=0, color_w_data=0 and in_ready=0.
REQ-038 While rst=1, SHALL clear the state to IDLE and clear the beat and word counters.
REQ-039 A reset asserted mid-frame SHALL abort the frame with no further write and no new_frame.
REQ-040 After reset deassertion, SHALL drive in_ready=1 on the first clk edge.

Verification
REQ-041 Bench SHALL cover: a full frame of 3072 random beats with valid held high, first beat carrying sof -> 768 writes at addresses 0..767 matching the packed data, one new_frame pulse one cycle after the write to 767, frame_count=1.
REQ-042 Bench SHALL cover: beats 0x00000001..0x00000004 with sof on the first -> color_w_data=0x00000004_00000003_00000002_00000001 at color_w_addr=0, with color_w_enable in the cycle after beat 4.
REQ-043 Bench SHALL cover: random in_valid gaps of 0-5 cycles over a full frame -> write data and addresses identical to the gapless run, exactly one new_frame.
REQ-044 Bench SHALL cover: sof reasserted after 10 words plus 2 beats -> err_sync=1, the next write goes to address 0 with the new data, exactly one new_frame after 768 further words.
REQ-045 Bench SHALL cover: beats with no sof after reset -> no writes, err_sync=1; err_clear -> err_sync=0.
REQ-046 Bench SHALL cover: rst pulsed mid-frame -> all outputs return to their reset values, no new_frame, and a following full frame completes with frame_count=1.
